// File: rtl/cpu_ctl_pkg.sv
// cpu_ctl_pkg: shared opcodes, FSM states, instruction classes and the
// datapath strobe bundle for the hardwired control sequencer.
// The WAIT state is only reachable when SINGLE_STEP_EN is defined.
package cpu_ctl_pkg;

   localparam int OPW = 5;
   localparam logic [OPW-1:0] ADD_OP = 5'b00011;

   localparam logic [OPW-1:0] OP_LD   = 5'b00000;
   localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPW-1:0] OP_ST   = 5'b00010;
   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_OR   = 5'b01011;
   localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
   localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
   localparam logic [OPW-1:0] OP_BR   = 5'b10011;
   localparam logic [OPW-1:0] OP_JR   = 5'b10100;
   localparam logic [OPW-1:0] OP_JAL  = 5'b10101;
   localparam logic [OPW-1:0] OP_IN   = 5'b10110;
   localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
   localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
   localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
   localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPW-1:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT, WAIT
   } state_t;

   typedef enum logic [3:0] {
      CLS_ALU, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_LD, CLS_LDI, CLS_ST,
      CLS_BR, CLS_JR, CLS_JAL, CLS_IO, CLS_MF, CLS_NOP
   } cls_t;

   // One bit per datapath control line; all-zero means the datapath idles.
   typedef struct packed {
      logic read, write, inc_pc, gra, grb, grc, rin, rout, ba_out, rlink_in;
      logic hi_in, lo_in, y_in, z_in, pc_in, ir_in, mar_in, mdr_in, outport_in, con_in;
      logic hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out, inport_out, c_out;
   } strobe_t;

   // halt and the unused opcodes fall into CLS_NOP; the FSM catches halt itself.
   function automatic cls_t opcode_class(input logic [OPW-1:0] op);
      cls_t c;
      c = CLS_NOP;
      case (op) inside
         [OP_ADD:OP_OR]:    c = CLS_ALU;
         [OP_ADDI:OP_ORI]:  c = CLS_IMM;
         OP_MUL, OP_DIV:    c = CLS_MULDIV;
         OP_NEG, OP_NOT:    c = CLS_UNARY;
         OP_LD:             c = CLS_LD;
         OP_LDI:            c = CLS_LDI;
         OP_ST:             c = CLS_ST;
         OP_BR:             c = CLS_BR;
         OP_JR:             c = CLS_JR;
         OP_JAL:            c = CLS_JAL;
         OP_IN, OP_OUT:     c = CLS_IO;
         OP_MFHI, OP_MFLO:  c = CLS_MF;
         default:           c = CLS_NOP;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/control_sequencer_ctl_decode.sv
// ctl_decode: purely combinational map from (state, instruction class) to
// the datapath strobe vector, ALU select and an end-of-instruction flag.
module ctl_decode
   import cpu_ctl_pkg::*;
(
   input  state_t         state,
   input  logic [OPW-1:0] ir_opcode,
   input  logic           con_ff,
   output strobe_t        strobes,
   output logic [OPW-1:0] alu_op,
   output logic           last_step
);

   cls_t cls;
   assign cls = opcode_class(ir_opcode);

   // Moore decode: fetch steps are class independent, execute steps per class.
   always_comb begin
      strobes   = '0;
      alu_op    = ADD_OP;
      last_step = 1'b0;
      case (state)
         T0: begin strobes.pc_out = 1'b1; strobes.mar_in = 1'b1; strobes.inc_pc = 1'b1; strobes.z_in = 1'b1; end
         T1: begin strobes.zlow_out = 1'b1; strobes.pc_in = 1'b1; strobes.read = 1'b1; strobes.mdr_in = 1'b1; end
         T2: begin strobes.mdr_out = 1'b1; strobes.ir_in = 1'b1; end
         T3, T4, T5, T6, T7: begin
            case (cls)
               CLS_ALU, CLS_IMM: begin
                  case (state)
                     T3: begin strobes.grb = 1'b1; strobes.rout = 1'b1; strobes.y_in = 1'b1; alu_op = ir_opcode; end
                     T4: begin
                        if (cls == CLS_IMM) strobes.c_out = 1'b1;
                        else begin strobes.grc = 1'b1; strobes.rout = 1'b1; end
                        strobes.z_in = 1'b1; alu_op = ir_opcode;
                     end
                     T5: begin strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1; last_step = 1'b1; end
                     default: ;
                  endcase
               end
               CLS_UNARY: begin
                  alu_op = ir_opcode;
                  if (state == T3) begin strobes.grb = 1'b1; strobes.rout = 1'b1; strobes.z_in = 1'b1; end
                  else begin strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1; last_step = 1'b1; end
               end
               CLS_MULDIV: begin
                  case (state)
                     T3: begin strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.y_in = 1'b1; alu_op = ir_opcode; end
                     T4: begin strobes.grb = 1'b1; strobes.rout = 1'b1; strobes.z_in = 1'b1; alu_op = ir_opcode; end
                     T5: begin strobes.zlow_out = 1'b1; strobes.lo_in = 1'b1; end
                     T6: begin strobes.zhigh_out = 1'b1; strobes.hi_in = 1'b1; last_step = 1'b1; end
                     default: ;
                  endcase
               end
               CLS_LD, CLS_LDI, CLS_ST: begin
                  // Shared effective-address calculation, then load, immediate or store tail.
                  case (state)
                     T3: begin strobes.grb = 1'b1; strobes.ba_out = 1'b1; strobes.y_in = 1'b1; end
                     T4: begin strobes.c_out = 1'b1; strobes.z_in = 1'b1; end
                     T5: begin
                        strobes.zlow_out = 1'b1;
                        if (cls == CLS_LDI) begin strobes.gra = 1'b1; strobes.rin = 1'b1; last_step = 1'b1; end
                        else strobes.mar_in = 1'b1;
                     end
                     T6: begin
                        strobes.mdr_in = 1'b1;
                        if (cls == CLS_ST) begin strobes.gra = 1'b1; strobes.rout = 1'b1; end
                        else strobes.read = 1'b1;
                     end
                     T7: begin
                        if (cls == CLS_ST) strobes.write = 1'b1;
                        else begin strobes.mdr_out = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1; end
                        last_step = 1'b1;
                     end
                     default: ;
                  endcase
               end
               CLS_BR: begin
                  case (state)
                     T3: begin strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.con_in = 1'b1; end
                     T4: begin strobes.pc_out = 1'b1; strobes.y_in = 1'b1; end
                     T5: begin strobes.c_out = 1'b1; strobes.z_in = 1'b1; end
                     T6: begin strobes.zlow_out = 1'b1; strobes.pc_in = con_ff; last_step = 1'b1; end
                     default: ;
                  endcase
               end
               CLS_JR: begin strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.pc_in = 1'b1; last_step = 1'b1; end
               CLS_JAL: begin
                  if (state == T3) begin strobes.pc_out = 1'b1; strobes.rlink_in = 1'b1; end
                  else begin strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.pc_in = 1'b1; last_step = 1'b1; end
               end
               CLS_IO: begin
                  strobes.gra = 1'b1; last_step = 1'b1;
                  if (ir_opcode == OP_IN) begin strobes.inport_out = 1'b1; strobes.rin = 1'b1; end
                  else begin strobes.rout = 1'b1; strobes.outport_in = 1'b1; end
               end
               CLS_MF: begin
                  strobes.gra = 1'b1; strobes.rin = 1'b1; last_step = 1'b1;
                  if (ir_opcode == OP_MFHI) strobes.hi_out = 1'b1;
                  else strobes.lo_out = 1'b1;
               end
               default: last_step = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit driving the CPU datapath
// through fetch (T0-T2) and per-class execute steps (T3-T7).
// Optional macro SINGLE_STEP_EN adds a step input and a WAIT state entered
// after every instruction.
module control_sequencer
   import cpu_ctl_pkg::*;
(
   input  logic           Clock,
   input  logic           clear,
   input  logic [OPW-1:0] ir_opcode,
   input  logic           CON_FF,
   input  logic           Stop,
`ifdef SINGLE_STEP_EN
   input  logic           step,
`endif
   output logic           Run,
   output logic [OPW-1:0] alu_op,
   output logic           Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout, Rlink_in,
   output logic           HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Outportin, CONin,
   output logic           HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout,
   output state_t         cur_state
);

   state_t  state, next_state, end_state;
   strobe_t strobes;
   logic    last_step;

   ctl_decode u_decode (
      .state     (state),
      .ir_opcode (ir_opcode),
      .con_ff    (CON_FF),
      .strobes   (strobes),
      .alu_op    (alu_op),
      .last_step (last_step)
   );

   // State register; clear abandons any in-flight instruction.
   always_ff @(posedge Clock) begin
      if (!clear) state <= RESET;
      else        state <= next_state;
   end

   // Next state: fixed fetch walk, class-dependent execute length, Stop checked on the way to T0.
   always_comb begin
      next_state = state;
`ifdef SINGLE_STEP_EN
      end_state = Stop ? HALT : WAIT;
`else
      end_state = Stop ? HALT : T0;
`endif
      case (state)
         RESET: next_state = Stop ? HALT : T0;
         T0:    next_state = T1;
         T1:    next_state = T2;
         T2:    next_state = T3;
         T3: begin
            if (ir_opcode == OP_HALT) next_state = HALT;
            else                      next_state = last_step ? end_state : T4;
         end
         T4:    next_state = last_step ? end_state : T5;
         T5:    next_state = last_step ? end_state : T6;
         T6:    next_state = last_step ? end_state : T7;
         T7:    next_state = end_state;
         HALT:  next_state = HALT;
`ifdef SINGLE_STEP_EN
         WAIT: begin
            if (Stop)      next_state = HALT;
            else if (step) next_state = T0;
            else           next_state = WAIT;
         end
`endif
         default: next_state = RESET;
      endcase
   end

   assign Run       = (state != HALT) && (state != WAIT);
   assign cur_state = state;

   assign Read      = strobes.read;
   assign Write     = strobes.write;
   assign IncPC     = strobes.inc_pc;
   assign Gra       = strobes.gra;
   assign Grb       = strobes.grb;
   assign Grc       = strobes.grc;
   assign Rin       = strobes.rin;
   assign Rout      = strobes.rout;
   assign BAout     = strobes.ba_out;
   assign Rlink_in  = strobes.rlink_in;
   assign HIin      = strobes.hi_in;
   assign LOin      = strobes.lo_in;
   assign Yin       = strobes.y_in;
   assign Zin       = strobes.z_in;
   assign PCin      = strobes.pc_in;
   assign IRin      = strobes.ir_in;
   assign MARin     = strobes.mar_in;
   assign MDRin     = strobes.mdr_in;
   assign Outportin = strobes.outport_in;
   assign CONin     = strobes.con_in;
   assign HIout     = strobes.hi_out;
   assign LOout     = strobes.lo_out;
   assign Zhighout  = strobes.zhigh_out;
   assign Zlowout   = strobes.zlow_out;
   assign PCout     = strobes.pc_out;
   assign MDRout    = strobes.mdr_out;
   assign Inportout = strobes.inport_out;
   assign Cout      = strobes.c_out;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit that sequences the CPU datapath through fetch (T0-T2) and per-class execute steps (T3-T7).
- Drives every datapath strobe that is currently hand-driven by benches: register-select, bus-out, register-in, memory and ALU-op.
- Sits beside the datapath and reads only IR[31:27], CON_FF and Stop back from it.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- ADD_OP, 5'b00011, ALU opcode driven during PC increment and address/offset calculation.

Ports:
- Clock  in  1  system clock; all state changes on posedge.
- clear  in  1  synchronous, active-low reset.
- ir_opcode  in  OPW  IR[31:27]; valid from T3 onward.
- CON_FF  in  1  branch-condition flag.
- Stop  in  1  halt request.
- Run  out  1  high while sequencing; low in HALT.
- alu_op  out  OPW  ALU operation select.
- Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout, Rlink_in  out  1 each  datapath strobes; Rlink_in is the R15 write enable for jal.
- HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Outportin, CONin  out  1 each  register loads.
- HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout  out  1 each  bus drivers.

Behaviour:
- Reset: clear=0 at a posedge forces state RESET, with all strobes 0, Run=1 and alu_op=ADD_OP. Reset mid-instruction abandons the instruction. The first cycle after clear deasserts is RESET, then T0.
- Outputs are a combinational decode of the registered state and ir_opcode. Every step lasts exactly one clock. At most one bus driver is high in any state.
- Fetch:
  - T0: PCout MARin IncPC Zin.
  - T1: Zlowout PCin Read MDRin.
  - T2: MDRout IRin.
- Execute, by opcode:
  - Reg ALU (00011-01011): T3 Grb Rout Yin; T4 Grc Rout Zin (alu_op=ir_opcode); T5 Zlowout Gra Rin.
  - Imm ALU (01100-01110): T3 Grb Rout Yin; T4 Cout Zin; T5 Zlowout Gra Rin.
  - neg/not (10001, 10010): T3 Grb Rout Zin; T4 Zlowout Gra Rin.
  - mul/div (01111, 10000): T3 Gra Rout Yin; T4 Grb Rout Zin; T5 Zlowout LOin; T6 Zhighout HIin.
  - ld (00000): T3 Grb BAout Yin; T4 Cout Zin (ADD_OP); T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - ldi (00001): T3-T4 as ld; T5 Zlowout Gra Rin.
  - st (00010): T3-T5 as ld; T6 Gra Rout MDRin (Read=0); T7 Write.
  - br (10011): T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin (ADD_OP); T6 Zlowout, with PCin=CON_FF sampled in T6.
  - jr (10100): T3 Gra Rout PCin.
  - jal (10101): T3 PCout Rlink_in; T4 Gra Rout PCin.
  - in (10110): T3 Inportout Gra Rin.
  - out (10111): T3 Gra Rout Outportin.
  - mfhi (11000): T3 HIout Gra Rin.
  - mflo (11001): T3 LOout Gra Rin.
  - nop (11010) and unused opcodes (11100-11111): T3 with no strobes.
  - halt (11011): T3 goes to HALT.
- After an instruction's last step, the next state is T0.
- Stop is sampled on the transition into T0. If high, go to HALT instead; the in-flight instruction always completes.
- HALT: Run=0 and all strobes 0. Leave only via clear.
- alu_op equals ir_opcode in T3-T4 of ALU classes, and ADD_OP otherwise.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined: adds input step (1 bit) and state WAIT. After each instruction's last step the FSM enters WAIT (Run=0, strobes 0). A step high at a posedge moves WAIT to T0; Stop is still honoured first.
- Undefined: no step port and no WAIT; back-to-back execution.

Decomposition:
- Package cpu_ctl_pkg holds:
  - opcode localparams (OP_LD...OP_HALT);
  - the state enum (RESET, T0-T7, HALT, WAIT);
  - ADD_OP;
  - an instruction-class enum (CLS_ALU, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_LD, CLS_LDI, CLS_ST, CLS_BR, CLS_JR, CLS_JAL, CLS_IO, CLS_MF, CLS_NOP).
- One sub-module, ctl_decode: combinational opcode-to-class and (state, class)-to-strobe-vector map. The top holds the FSM register and the next-state logic.

Test Plan:
- Hold clear=0 for 2 cycles, then release -> all strobes 0 and Run=1 during reset; RESET then T0 with PCout=MARin=IncPC=Zin=1.
- ir_opcode=00011 (add) -> T3 Grb Rout Yin, T4 Grc Rout Zin with alu_op=00011, T5 Zlowout Gra Rin, then T0; 6 cycles T0-T5.
- ir_opcode=00010 (st) -> T6 MDRin=1 with Read=0, T7 Write=1, then T0; ld (00000) shows Read MDRin at T6 and MDRout Gra Rin at T7.
- br with CON_FF=0, then repeated with CON_FF=1 -> PCin=0 and PCin=1 respectively in T6; alu_op=00011 in T5.
- Stop=1 during T4 of add -> T5 completes, then HALT with Run=0. Separately, ir_opcode=11011 -> HALT after T3. clear=0 at T5 of ld -> RESET next cycle, and Read/MDRin never assert.
- Under SINGLE_STEP_EN: after mflo the FSM idles in WAIT for 5 cycles; step=1 for one cycle -> T0.
